// File: rtl/scoreboard_multi_display.sv
// rtl/scoreboard_multi_display.sv - seven-segment score/level/debug display with blink, high score and overflow
module scoreboard_multi_display #(
  parameter int DIGITS      = 6,
  parameter int SCORE_WIDTH = 8,
  parameter int LZB         = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     screenClock,
  input  logic [SCORE_WIDTH-1:0]   size,
  input  logic [2:0]               level,
  input  logic                     gameOver,
  input  logic                     debugMode,
  input  logic [7:0]               appleLocX,
  input  logic [8:0]               appleLocY,
  output logic [7*DIGITS-1:0]      seg,
  output logic                     busy,
  output logic [SCORE_WIDTH-1:0]   highScore
);

  localparam int CW    = (SCORE_WIDTH > 9) ? SCORE_WIDTH : 9;
  localparam int CNT_W = $clog2(CW) + 1;
  localparam int H     = DIGITS / 2;
  localparam int BW    = 4 * DIGITS;
  localparam int SW    = 7 * DIGITS;

  typedef enum logic [2:0] {IDLE, SHIFT_A, LATCH_A, SHIFT_B, LATCH_B} state_t;

  state_t             state, next_state;
  logic               sc_q, go_q, blink_phase, dbg_q, start, last;
  logic [2:0]         level_q;
  logic [8:0]         y_q;
  logic [CNT_W-1:0]   cnt;
  logic [BW-1:0]      bcd, adj;
  logic [CW-1:0]      bin;
  logic [7*H-1:0]     x_field;
  logic [SW-1:0]      score_w, half_w, normal_word, debug_word;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  endfunction

  // Renders the low f digits of b; digits above the field stay blank.
  function automatic logic [SW-1:0] fmt_field(input logic [BW-1:0] b, input int f);
    logic [SW-1:0] r;
    logic          ovf;
    logic          lead;
    logic [3:0]    nib;
    r    = '1;
    ovf  = 1'b0;
    lead = (LZB != 0);
    for (int i = 0; i < DIGITS; i++)
      if (i >= f && b[4*i +: 4] != 4'd0) ovf = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i < f) begin
        nib = b[4*i +: 4];
        if (ovf) r[7*i +: 7] = 7'h3F;
        else if (lead && nib == 4'd0 && i != 0) r[7*i +: 7] = 7'h7F;
        else begin
          r[7*i +: 7] = dec(nib);
          lead = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign busy  = (state != IDLE);
  assign start = screenClock & ~sc_q & ~busy;
  assign last  = (cnt == CNT_W'(CW - 1));

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    score_w     = fmt_field(bcd, DIGITS - 2);
    half_w      = fmt_field(bcd, H);
    normal_word = score_w;
    normal_word[7*(DIGITS-2) +: 7] = 7'h7F;
    normal_word[7*(DIGITS-1) +: 7] = dec({1'b0, level_q});
    debug_word  = {half_w[7*H-1:0], x_field};
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT_A;
      SHIFT_A: if (last) next_state = LATCH_A;
      LATCH_A: next_state = dbg_q ? SHIFT_B : IDLE;
      SHIFT_B: if (last) next_state = LATCH_B;
      LATCH_B: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sc_q        <= 1'b0;
      go_q        <= 1'b0;
      highScore   <= '0;
      blink_phase <= 1'b0;
      seg         <= '1;
      bcd         <= '0;
      bin         <= '0;
      cnt         <= '0;
      level_q     <= '0;
      dbg_q       <= 1'b0;
      y_q         <= '0;
      x_field     <= '1;
    end else begin
      sc_q <= screenClock;
      go_q <= gameOver;
      // High score tracks the live score and is independent of the conversion engine.
      if (gameOver && !go_q && size > highScore) highScore <= size;
      case (state)
        IDLE: if (start) begin
          bin         <= debugMode ? CW'(appleLocX) : CW'(size);
          bcd         <= '0;
          cnt         <= '0;
          level_q     <= level;
          dbg_q       <= debugMode;
          y_q         <= appleLocY;
          blink_phase <= gameOver ? ~blink_phase : 1'b0;
        end
        SHIFT_A, SHIFT_B: begin
          bcd <= {adj[BW-2:0], bin[CW-1]};
          bin <= {bin[CW-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        LATCH_A: begin
          cnt <= '0;
          if (dbg_q) begin
            x_field <= half_w[7*H-1:0];
            bcd     <= '0;
            bin     <= CW'(y_q);
          end else begin
            seg <= blink_phase ? '1 : normal_word;
          end
        end
        LATCH_B: seg <= blink_phase ? '1 : debug_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_multi_display.sv
// tb/tb_scoreboard_multi_display.sv - directed self-checking bench for scoreboard_multi_display
module tb_scoreboard_multi_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        screenClock = 1'b0;
  logic [7:0]  size = '0;
  logic [2:0]  level = '0;
  logic        gameOver = 1'b0;
  logic        debugMode = 1'b0;
  logic [7:0]  appleLocX = '0;
  logic [8:0]  appleLocY = '0;
  logic [41:0] seg;
  logic        busy;
  logic [7:0]  highScore;
  logic [27:0] seg4;
  logic        busy4;
  logic [7:0]  high_score4;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  scoreboard_multi_display #(.DIGITS(6), .SCORE_WIDTH(8), .LZB(1)) dut (
    .clock(clock), .reset(reset), .screenClock(screenClock), .size(size), .level(level),
    .gameOver(gameOver), .debugMode(debugMode), .appleLocX(appleLocX), .appleLocY(appleLocY),
    .seg(seg), .busy(busy), .highScore(highScore)
  );

  scoreboard_multi_display #(.DIGITS(4), .SCORE_WIDTH(8), .LZB(1)) dut4 (
    .clock(clock), .reset(reset), .screenClock(screenClock), .size(size), .level(level),
    .gameOver(gameOver), .debugMode(debugMode), .appleLocX(appleLocX), .appleLocY(appleLocY),
    .seg(seg4), .busy(busy4), .highScore(high_score4)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the bench in cycle E+1 with screenClock low again.
  task automatic rise();
    screenClock = 1'b1;
    tick();
    screenClock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    total++; if (seg !== {42{1'b1}}) $display("FAIL reset_seg got=%h exp=%h", seg, {42{1'b1}}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (highScore !== 8'd0) $display("FAIL reset_high got=%0d exp=0", highScore); else passed++;
    total++; if (seg4 !== {28{1'b1}}) $display("FAIL reset_seg4 got=%h exp=%h", seg4, {28{1'b1}}); else passed++;
  endtask

  task automatic test_normal();
    logic [41:0] exp;
    logic [27:0] exp4;
    exp  = {7'h24, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30};
    exp4 = {7'h24, 7'h7F, 7'h3F, 7'h3F};
    size = 8'd123; level = 3'd2; debugMode = 1'b0;
    tick();
    rise();
    total++; if (busy !== 1'b1) $display("FAIL normal_busy_e1 got=%b exp=1", busy); else passed++;
    size = 8'd99; level = 3'd7;
    tick(9);
    total++; if (seg !== {42{1'b1}}) $display("FAIL normal_seg_e10 got=%h exp=%h", seg, {42{1'b1}}); else passed++;
    tick();
    total++; if (seg !== exp) $display("FAIL normal_seg got=%h exp=%h", seg, exp); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL normal_busy_e11 got=%b exp=0", busy); else passed++;
    total++; if (seg4 !== exp4) $display("FAIL normal_seg4 got=%h exp=%h", seg4, exp4); else passed++;
  endtask

  task automatic test_debug();
    logic [41:0] prev;
    logic [41:0] exp;
    logic [27:0] exp4;
    prev = {7'h24, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30};
    exp  = {7'h7F, 7'h19, 7'h24, 7'h7F, 7'h24, 7'h02};
    exp4 = {7'h19, 7'h24, 7'h24, 7'h02};
    debugMode = 1'b1; appleLocX = 8'd26; appleLocY = 9'd42;
    tick();
    rise();
    appleLocX = 8'd0; appleLocY = 9'd0; debugMode = 1'b0;
    tick(19);
    total++; if (seg !== prev) $display("FAIL debug_seg_e20 got=%h exp=%h", seg, prev); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL debug_busy_e20 got=%b exp=1", busy); else passed++;
    tick();
    total++; if (seg !== exp) $display("FAIL debug_seg got=%h exp=%h", seg, exp); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL debug_busy_e21 got=%b exp=0", busy); else passed++;
    total++; if (seg4 !== exp4) $display("FAIL debug_seg4 got=%h exp=%h", seg4, exp4); else passed++;
  endtask

  task automatic test_overflow();
    logic [41:0] exp;
    logic [27:0] exp4;
    exp  = {7'h12, 7'h7F, 7'h7F, 7'h24, 7'h12, 7'h12};
    exp4 = {7'h12, 7'h7F, 7'h3F, 7'h3F};
    size = 8'd255; level = 3'd5; debugMode = 1'b0;
    tick();
    rise();
    tick(10);
    total++; if (seg4 !== exp4) $display("FAIL overflow_seg4 got=%h exp=%h", seg4, exp4); else passed++;
    total++; if (seg !== exp) $display("FAIL overflow_seg got=%h exp=%h", seg, exp); else passed++;
  endtask

  task automatic test_blink_highscore();
    logic [41:0] score;
    score = {7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h78};
    size = 8'd37; level = 3'd1; gameOver = 1'b1;
    tick(2);
    total++; if (highScore !== 8'd37) $display("FAIL high_first got=%0d exp=37", highScore); else passed++;
    for (int r = 0; r < 4; r++) begin
      rise();
      tick(12);
      if (r % 2 == 0) begin
        total++; if (seg !== {42{1'b1}}) $display("FAIL blink_blank%0d got=%h exp=%h", r, seg, {42{1'b1}}); else passed++;
      end else begin
        total++; if (seg !== score) $display("FAIL blink_score%0d got=%h exp=%h", r, seg, score); else passed++;
      end
    end
    gameOver = 1'b0; size = 8'd20;
    tick();
    gameOver = 1'b1;
    tick(2);
    total++; if (highScore !== 8'd37) $display("FAIL high_keep got=%0d exp=37", highScore); else passed++;
    gameOver = 1'b0; size = 8'd50;
    tick();
    gameOver = 1'b1;
    tick(2);
    total++; if (highScore !== 8'd50) $display("FAIL high_raise got=%0d exp=50", highScore); else passed++;
    total++; if (high_score4 !== 8'd50) $display("FAIL high_raise4 got=%0d exp=50", high_score4); else passed++;
    gameOver = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [41:0] prev_seg;
    logic [41:0] exp;
    logic        prev_busy;
    int          seg_changes;
    int          busy_pulses;
    exp = {7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    size = 8'd7; level = 3'd3; debugMode = 1'b0;
    tick();
    prev_seg = seg; prev_busy = busy;
    seg_changes = 0; busy_pulses = 0;
    for (int k = 0; k < 40; k++) begin
      screenClock = (k == 0 || k == 5);
      tick();
      if (seg !== prev_seg) seg_changes++;
      if (busy && !prev_busy) busy_pulses++;
      prev_seg = seg; prev_busy = busy;
    end
    screenClock = 1'b0;
    total++; if (seg_changes != 1) $display("FAIL b2b_seg_updates got=%0d exp=1", seg_changes); else passed++;
    total++; if (busy_pulses != 1) $display("FAIL b2b_busy_pulses got=%0d exp=1", busy_pulses); else passed++;
    total++; if (seg !== exp) $display("FAIL b2b_seg got=%h exp=%h", seg, exp); else passed++;
  endtask

  task automatic test_reset_mid();
    size = 8'd88;
    tick();
    rise();
    tick(3);
    total++; if (busy !== 1'b1) $display("FAIL mid_busy_e4 got=%b exp=1", busy); else passed++;
    reset = 1'b0;
    tick();
    total++; if (seg !== {42{1'b1}}) $display("FAIL mid_seg got=%h exp=%h", seg, {42{1'b1}}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
    total++; if (highScore !== 8'd0) $display("FAIL mid_high got=%0d exp=0", highScore); else passed++;
    reset = 1'b1;
    tick(15);
    total++; if (seg !== {42{1'b1}}) $display("FAIL mid_no_resume got=%h exp=%h", seg, {42{1'b1}}); else passed++;
  endtask

  initial begin
    tick();
    test_reset();
    test_normal();
    test_debug();
    test_overflow();
    test_blink_highscore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
